// File: rtl/multichannel_frequency_analyzer_pkg.sv
// Shared codes and window/timeout helpers for the multichannel frequency analyzer.
package frequency_analyzer_pkg;

    typedef enum logic [1:0] {
        ClsNone = 2'd0,
        ClsF1   = 2'd1,
        ClsF2   = 2'd2
    } cls_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StMeasure = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RdF1Time     = 2'd0,
        RdF2Time     = 2'd1,
        RdStatus     = 2'd2,
        RdLastPeriod = 2'd3
    } rd_sel_e;

    function automatic longint unsigned win_lo(longint unsigned clk, longint unsigned freq,
                                               longint unsigned dev);
        longint unsigned p;
        p = clk / freq;
        return p - p * dev / 100;
    endfunction

    function automatic longint unsigned win_hi(longint unsigned clk, longint unsigned freq,
                                               longint unsigned dev);
        longint unsigned p;
        p = clk / freq;
        return p + p * dev / 100;
    endfunction

    function automatic longint unsigned timeout_cycles(longint unsigned clk, longint unsigned f1,
                                                       longint unsigned f2, longint unsigned dev);
        longint unsigned hi1;
        longint unsigned hi2;
        hi1 = win_hi(clk, f1, dev);
        hi2 = win_hi(clk, f2, dev);
        return 2 * ((hi1 > hi2) ? hi1 : hi2);
    endfunction

endpackage

// File: rtl/multichannel_frequency_analyzer_if.sv
// Control, pixel stream, read port and interrupt signals of the frequency analyzer.
interface multichannel_frequency_analyzer_if #(
    parameter int unsigned CHANNELS      = 3,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned COUNTER_WIDTH = 32
);
    logic                     start;
    logic                     stop;
    logic                     clear;
    logic                     pixel_valid;
    logic                     line_start;
    logic [DATA_WIDTH-1:0]    data;
    logic [DATA_WIDTH-1:0]    threshold;
    logic                     rd_en;
    logic [3:0]               rd_channel;
    logic [1:0]               rd_sel;
    logic [COUNTER_WIDTH-1:0] rd_data;
    logic                     rd_valid;
    logic                     irq;
    logic [CHANNELS-1:0]      irq_status;
    logic [CHANNELS-1:0]      irq_ack;

    modport master (
        output start, stop, clear, pixel_valid, line_start, data, threshold,
        output rd_en, rd_channel, rd_sel, irq_ack,
        input  rd_data, rd_valid, irq, irq_status
    );

    modport slave (
        input  start, stop, clear, pixel_valid, line_start, data, threshold,
        input  rd_en, rd_channel, rd_sel, irq_ack,
        output rd_data, rd_valid, irq, irq_status
    );
endinterface

// File: rtl/multichannel_frequency_analyzer_channel.sv
// One monitored pixel: sample, rising-edge detect, period FSM, classification, accumulators.
module frequency_channel
    import frequency_analyzer_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH       = 32,
    parameter int unsigned CLOCK               = 100000000,
    parameter int unsigned FREQUENCY_1         = 9000,
    parameter int unsigned FREQUENCY_2         = 11000,
    parameter int unsigned FREQUENCY_DEVIATION = 10
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     enable_i,
    input  logic                     sample_en_i,
    input  logic                     sample_bit_i,
    output logic [COUNTER_WIDTH-1:0] f1_time_o,
    output logic [COUNTER_WIDTH-1:0] f2_time_o,
    output logic [COUNTER_WIDTH-1:0] last_period_o,
    output state_e                   state_o,
    output cls_e                     class_o,
    output logic                     class_change_o
);
    localparam longint unsigned Lo1 = win_lo(CLOCK, FREQUENCY_1, FREQUENCY_DEVIATION);
    localparam longint unsigned Hi1 = win_hi(CLOCK, FREQUENCY_1, FREQUENCY_DEVIATION);
    localparam longint unsigned Lo2 = win_lo(CLOCK, FREQUENCY_2, FREQUENCY_DEVIATION);
    localparam longint unsigned Hi2 = win_hi(CLOCK, FREQUENCY_2, FREQUENCY_DEVIATION);
    localparam longint unsigned Timeout =
        timeout_cycles(CLOCK, FREQUENCY_1, FREQUENCY_2, FREQUENCY_DEVIATION);
    localparam logic [COUNTER_WIDTH-1:0] CntMax = '1;
    localparam logic [COUNTER_WIDTH-1:0] CntOne = COUNTER_WIDTH'(1);

    logic samp_q, samp_prev_q, rise;
    state_e state_q, state_d;
    cls_e cls_q, cls_d, meas_cls;
    logic [COUNTER_WIDTH-1:0] period_q, period_d, last_q, last_d, f1_q, f1_d, f2_q, f2_d;
    logic [63:0] period_ext;

    assign rise       = samp_q & ~samp_prev_q;
    assign period_ext = 64'(period_q);

    always_comb begin
        meas_cls = ClsNone;
        if (period_ext >= Lo1 && period_ext <= Hi1) begin
            meas_cls = ClsF1;
        end else if (period_ext >= Lo2 && period_ext <= Hi2) begin
            meas_cls = ClsF2;
        end
    end

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        period_d = period_q;
        last_d   = last_q;
        f1_d     = f1_q;
        f2_d     = f2_q;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d  = StArmed;
                    period_d = CntOne;
                end
            end
            StArmed, StMeasure: begin
                period_d = (period_q == CntMax) ? period_q : period_q + CntOne;
                if (period_ext > Timeout) begin
                    state_d = StIdle;
                    cls_d   = ClsNone;
                end else if (rise) begin
                    state_d  = StMeasure;
                    cls_d    = meas_cls;
                    last_d   = period_q;
                    period_d = CntOne;
                end
            end
            default: state_d = StIdle;
        endcase
        // Accumulation looks at the class held before any edge in this cycle.
        if (enable_i) begin
            if (cls_q == ClsF1 && f1_q != CntMax) f1_d = f1_q + CntOne;
            if (cls_q == ClsF2 && f2_q != CntMax) f2_d = f2_q + CntOne;
        end
        if (clear_i) begin
            state_d  = StIdle;
            cls_d    = ClsNone;
            period_d = '0;
            last_d   = '0;
            f1_d     = '0;
            f2_d     = '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            samp_q      <= 1'b0;
            samp_prev_q <= 1'b0;
            state_q     <= StIdle;
            cls_q       <= ClsNone;
            period_q    <= '0;
            last_q      <= '0;
            f1_q        <= '0;
            f2_q        <= '0;
        end else begin
            if (sample_en_i) samp_q <= sample_bit_i;
            samp_prev_q <= samp_q;
            state_q     <= state_d;
            cls_q       <= cls_d;
            period_q    <= period_d;
            last_q      <= last_d;
            f1_q        <= f1_d;
            f2_q        <= f2_d;
        end
    end

    assign f1_time_o      = f1_q;
    assign f2_time_o      = f2_q;
    assign last_period_o  = last_q;
    assign state_o        = state_q;
    assign class_o        = cls_q;
    assign class_change_o = (cls_d != cls_q);
endmodule

// File: rtl/multichannel_frequency_analyzer.sv
// N-channel pixel frequency analyzer: enable, pixel counter, per-channel trackers, read mux, irq.
// Define FA_CLASS_IRQ_EN to build the sticky class-change interrupt; otherwise irq is tied low.
module multichannel_frequency_analyzer
    import frequency_analyzer_pkg::*;
#(
    parameter int unsigned CHANNELS            = 3,
    parameter int unsigned DATA_WIDTH          = 8,
    parameter int unsigned INDEX_WIDTH         = 10,
    parameter logic [CHANNELS*INDEX_WIDTH-1:0] PIXEL_INDICES = {10'd1023, 10'd511, 10'd15},
    parameter int unsigned CLOCK               = 100000000,
    parameter int unsigned FREQUENCY_1         = 9000,
    parameter int unsigned FREQUENCY_2         = 11000,
    parameter int unsigned FREQUENCY_DEVIATION = 10,
    parameter int unsigned COUNTER_WIDTH       = 32
) (
    input logic                             clock_i,
    input logic                             reset_i,
    multichannel_frequency_analyzer_if.slave bus
);
    logic enable_q, enable_d;
    logic [INDEX_WIDTH-1:0] pix_cnt_q, cur_idx;
    logic sample_bit;
    logic [CHANNELS-1:0] class_change;
    logic [COUNTER_WIDTH-1:0] rd_data_q, rd_word;
    logic rd_valid_q;

    // Padded to 16 so any 4-bit rd_channel indexes safely; unused slots read as zero.
    logic [COUNTER_WIDTH-1:0] f1_all [16];
    logic [COUNTER_WIDTH-1:0] f2_all [16];
    logic [COUNTER_WIDTH-1:0] lp_all [16];
    state_e st_all [16];
    cls_e   cls_all [16];

    assign enable_d   = bus.stop ? 1'b0 : (bus.start ? 1'b1 : enable_q);
    assign cur_idx    = bus.line_start ? '0 : pix_cnt_q;
    assign sample_bit = (bus.data >= bus.threshold);

    for (genvar ch = 0; ch < 16; ch++) begin : g_ch
        if (ch < CHANNELS) begin : g_live
            logic sample_en;
            assign sample_en = bus.pixel_valid & enable_q &
                               (cur_idx == PIXEL_INDICES[ch*INDEX_WIDTH +: INDEX_WIDTH]);
            frequency_channel #(
                .COUNTER_WIDTH      (COUNTER_WIDTH),
                .CLOCK              (CLOCK),
                .FREQUENCY_1        (FREQUENCY_1),
                .FREQUENCY_2        (FREQUENCY_2),
                .FREQUENCY_DEVIATION(FREQUENCY_DEVIATION)
            ) u_channel (
                .clock_i       (clock_i),
                .reset_i       (reset_i),
                .clear_i       (bus.clear),
                .enable_i      (enable_q),
                .sample_en_i   (sample_en),
                .sample_bit_i  (sample_bit),
                .f1_time_o     (f1_all[ch]),
                .f2_time_o     (f2_all[ch]),
                .last_period_o (lp_all[ch]),
                .state_o       (st_all[ch]),
                .class_o       (cls_all[ch]),
                .class_change_o(class_change[ch])
            );
        end else begin : g_pad
            assign f1_all[ch]  = '0;
            assign f2_all[ch]  = '0;
            assign lp_all[ch]  = '0;
            assign st_all[ch]  = StIdle;
            assign cls_all[ch] = ClsNone;
        end
    end

    always_comb begin
        rd_word = '0;
        unique case (rd_sel_e'(bus.rd_sel))
            RdF1Time:     rd_word = f1_all[bus.rd_channel];
            RdF2Time:     rd_word = f2_all[bus.rd_channel];
            RdStatus:     rd_word = COUNTER_WIDTH'({st_all[bus.rd_channel],
                                                    cls_all[bus.rd_channel]});
            RdLastPeriod: rd_word = lp_all[bus.rd_channel];
            default:      rd_word = '0;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            enable_q   <= 1'b0;
            pix_cnt_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            enable_q   <= enable_d;
            if (bus.pixel_valid && enable_q) pix_cnt_q <= cur_idx + INDEX_WIDTH'(1);
            if (bus.rd_en) rd_data_q <= rd_word;
            rd_valid_q <= bus.rd_en;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

`ifdef FA_CLASS_IRQ_EN
    logic [CHANNELS-1:0] irq_status_q, irq_status_d;
    logic irq_q;

    always_comb begin
        irq_status_d = (irq_status_q & ~bus.irq_ack) | class_change;
        if (bus.clear) irq_status_d = '0;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            irq_status_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            irq_status_q <= irq_status_d;
            irq_q        <= |irq_status_d;
        end
    end

    assign bus.irq_status = irq_status_q;
    assign bus.irq        = irq_q;
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{bus.irq_ack, class_change};
    assign bus.irq_status    = '0;
    assign bus.irq           = 1'b0;
`endif
endmodule

// File: tb/tb_multichannel_frequency_analyzer.sv
// Directed bench: 3-channel analyzer on a 50-pixel line stream plus an 8-bit saturation build.
module tb_multichannel_frequency_analyzer;

`ifdef FA_CLASS_IRQ_EN
    localparam logic IrqOn = 1'b1;
`else
    localparam logic IrqOn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   pix = 0;
    int   line_cnt = 0;
    int   cyc2 = 0;
    logic b2_run = 1'b0;
    int   half_lines [3] = '{0, 0, 0};
    logic [31:0] va, vb;

    always #5 clk = ~clk;

    multichannel_frequency_analyzer_if #(
        .CHANNELS(3), .DATA_WIDTH(8), .COUNTER_WIDTH(32)
    ) b1 ();
    multichannel_frequency_analyzer_if #(
        .CHANNELS(1), .DATA_WIDTH(8), .COUNTER_WIDTH(8)
    ) b2 ();

    multichannel_frequency_analyzer #(
        .CHANNELS           (3),
        .DATA_WIDTH         (8),
        .INDEX_WIDTH        (10),
        .PIXEL_INDICES      ({10'd40, 10'd20, 10'd5}),
        .CLOCK              (1000000),
        .FREQUENCY_1        (1000),
        .FREQUENCY_2        (2000),
        .FREQUENCY_DEVIATION(10),
        .COUNTER_WIDTH      (32)
    ) dut (
        .clock_i(clk),
        .reset_i(rst),
        .bus    (b1)
    );

    multichannel_frequency_analyzer #(
        .CHANNELS           (1),
        .DATA_WIDTH         (8),
        .INDEX_WIDTH        (4),
        .PIXEL_INDICES      (4'd0),
        .CLOCK              (1000),
        .FREQUENCY_1        (100),
        .FREQUENCY_2        (200),
        .FREQUENCY_DEVIATION(10),
        .COUNTER_WIDTH      (8)
    ) dut_sat (
        .clock_i(clk),
        .reset_i(rst),
        .bus    (b2)
    );

    function automatic logic lvl(input int c);
        if (half_lines[c] == 0) return 1'b0;
        return ((line_cnt / half_lines[c]) % 2) == 1;
    endfunction

    function automatic logic [7:0] pix_data(input int p);
        if (p == 5)  return lvl(0) ? 8'd200 : 8'd0;
        if (p == 20) return lvl(1) ? 8'd200 : 8'd0;
        if (p == 40) return lvl(2) ? 8'd200 : 8'd0;
        return 8'd0;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            b1.line_start = (pix == 0);
            b1.data       = pix_data(pix);
            b2.data       = (b2_run && ((cyc2 / 5) % 2 == 1)) ? 8'd200 : 8'd0;
            @(posedge clk);
            #1;
            cyc2++;
            if (pix == 49) begin
                pix = 0;
                line_cnt++;
            end else begin
                pix++;
            end
        end
    endtask

    task automatic rd(input int ch, input int sel, output logic [31:0] val);
        b1.rd_en      = 1'b1;
        b1.rd_channel = 4'(ch);
        b1.rd_sel     = 2'(sel);
        step(1);
        b1.rd_en = 1'b0;
        val      = b1.rd_data;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        {b1.start, b1.stop, b1.clear, b1.rd_en} = '0;
        b1.pixel_valid = 1'b1;
        b1.line_start  = 1'b0;
        b1.data        = '0;
        b1.threshold   = 8'd128;
        b1.rd_channel  = '0;
        b1.rd_sel      = '0;
        b1.irq_ack     = '0;
        {b2.start, b2.stop, b2.clear, b2.rd_en, b2.pixel_valid, b2.line_start} = '0;
        b2.data        = '0;
        b2.threshold   = 8'd128;
        b2.rd_channel  = '0;
        b2.rd_sel      = '0;
        b2.irq_ack     = '0;

        step(3);
        rst = 1'b0;
        chk("reset_rd_valid", 32'(b1.rd_valid), 32'd0);
        chk("reset_rd_data", b1.rd_data, 32'd0);
        chk("reset_irq", 32'(b1.irq), 32'd0);
        chk("reset_irq_status", 32'(b1.irq_status), 32'd0);

        b1.start = 1'b1;
        step(1);
        b1.start = 1'b0;
        rd(0, 0, va);
        chk("start_f1_ch0", va, 32'd0);
        chk("rd_valid_after_en", 32'(b1.rd_valid), 32'd1);
        step(1);
        chk("rd_valid_drops", 32'(b1.rd_valid), 32'd0);
        rd(0, 2, va);
        chk("start_status_ch0", va, 32'd0);

        // ch0: 10 lines high / 10 lines low -> 1000-cycle period
        half_lines[0] = 10;
        step(3200);
        rd(0, 2, va);
        chk("ch0_status_meas_f1", va, 32'd9);
        rd(0, 3, va);
        chk("ch0_last_period", va, 32'd1000);
        rd(0, 0, va);
        rd(0, 0, vb);
        chk("ch0_f1_grows_1", vb - va, 32'd1);

        // ch1: 500-cycle period -> F2
        half_lines[1] = 5;
        step(2000);
        rd(1, 2, va);
        chk("ch1_status_meas_f2", va, 32'd10);
        chk("irq_status_after_f2", 32'(b1.irq_status), IrqOn ? 32'd3 : 32'd0);
        chk("irq_after_f2", 32'(b1.irq), IrqOn ? 32'd1 : 32'd0);
        b1.irq_ack = 3'b010;
        step(1);
        b1.irq_ack = 3'b000;
        step(1);
        chk("irq_status_ack1", 32'(b1.irq_status), IrqOn ? 32'd1 : 32'd0);
        b1.irq_ack = 3'b001;
        step(1);
        b1.irq_ack = 3'b000;
        step(1);
        chk("irq_status_ack_all", 32'(b1.irq_status), 32'd0);
        chk("irq_ack_all", 32'(b1.irq), 32'd0);

        // ch0 stops toggling: timeout back to IDLE
        half_lines[0] = 0;
        step(2300);
        rd(0, 2, va);
        chk("ch0_timeout_status", va, 32'd0);
        rd(0, 0, va);
        step(5);
        rd(0, 0, vb);
        chk("ch0_f1_frozen", vb - va, 32'd0);

        // start and stop together disable accumulation
        b1.start = 1'b1;
        b1.stop  = 1'b1;
        step(1);
        b1.start = 1'b0;
        b1.stop  = 1'b0;
        rd(1, 1, va);
        step(3);
        rd(1, 1, vb);
        chk("startstop_f2_frozen", vb - va, 32'd0);
        b1.start = 1'b1;
        step(1);
        b1.start = 1'b0;
        rd(1, 1, va);
        rd(1, 1, vb);
        chk("restart_f2_grows_1", vb - va, 32'd1);

        b1.clear = 1'b1;
        step(1);
        b1.clear = 1'b0;
        rd(0, 0, va);
        chk("clear_f1_ch0", va, 32'd0);
        rd(1, 1, va);
        chk("clear_f2_ch1", va, 32'd0);
        rd(1, 3, va);
        chk("clear_last_period_ch1", va, 32'd0);
        chk("clear_irq_status", 32'(b1.irq_status), 32'd0);

        rd(5, 0, va);
        chk("rd_ch5_data", va, 32'd0);
        chk("rd_ch5_valid", 32'(b1.rd_valid), 32'd1);

        // 8-bit build: 10-cycle period is F1, accumulator must stop at 8'hFF
        b2.start       = 1'b1;
        b2.pixel_valid = 1'b1;
        b2.line_start  = 1'b1;
        b2_run         = 1'b1;
        step(1);
        b2.start = 1'b0;
        step(400);
        b2.rd_en  = 1'b1;
        b2.rd_sel = 2'd0;
        step(1);
        b2.rd_en = 1'b0;
        chk("sat_f1_ff", 32'(b2.rd_data), 32'hFF);
        step(5);
        b2.rd_en = 1'b1;
        step(1);
        b2.rd_en = 1'b0;
        chk("sat_f1_hold", 32'(b2.rd_data), 32'hFF);
        b2.rd_en  = 1'b1;
        b2.rd_sel = 2'd2;
        step(1);
        b2.rd_en = 1'b0;
        chk("sat_status_f1", 32'(b2.rd_data), 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
